// File: rtl/mem_request_responder.sv
// Memory-side responder for the request unit. It serves instruction and data requests one at a
// time over a single RAM port and returns single-cycle ihit/dhit pulses with registered load data.
module mem_request_responder #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned D_STREAK_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemren,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmemren,
    input  logic              dmemwen,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic              ihit,
    output logic [DATA_W-1:0] imemload,
    output logic              dhit,
    output logic [DATA_W-1:0] dmemload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    localparam int unsigned        StreakW   = $clog2(D_STREAK_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(D_STREAK_MAX);
    localparam logic [StreakW-1:0] StreakOne = StreakW'(1);

    typedef enum logic [2:0] {StIdle, StDreq, StIreq, StDresp, StIresp} state_e;

    state_e              state_q, state_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [DATA_W-1:0]   imemload_q, imemload_d;
    logic [DATA_W-1:0]   dmemload_q, dmemload_d;
    logic                d_pending;

    assign d_pending = dmemren | dmemwen;
    assign imemload  = imemload_q;
    assign dmemload  = dmemload_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            streak_q   <= '0;
            imemload_q <= '0;
            dmemload_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            imemload_q <= imemload_d;
            dmemload_q <= dmemload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        imemload_d = imemload_q;
        dmemload_d = dmemload_q;
        ihit       = 1'b0;
        dhit       = 1'b0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;

        unique case (state_q)
            StIdle: begin
                // Data wins unless a waiting fetch has already seen D_STREAK_MAX data services.
                if (d_pending && (!imemren || (streak_q < StreakMax))) begin
                    state_d = StDreq;
                end else if (imemren) begin
                    state_d = StIreq;
                end
            end
            StDreq: begin
                ram_addr  = dmemaddr;
                ram_store = dmemstore;
                ram_wen   = dmemwen;
                ram_ren   = ~dmemwen;
                if (!d_pending) begin
                    state_d = StIdle;
                end else if (ram_ready) begin
                    state_d = StDresp;
                    if (!dmemwen) begin
                        dmemload_d = ram_load;
                    end
                end
            end
            StIreq: begin
                ram_ren  = 1'b1;
                ram_addr = imemaddr;
                if (!imemren) begin
                    state_d = StIdle;
                end else if (ram_ready) begin
                    state_d    = StIresp;
                    imemload_d = ram_load;
                end
            end
            StDresp: begin
                dhit    = 1'b1;
                state_d = StIdle;
                if (imemren) begin
                    if (streak_q < StreakMax) begin
                        streak_d = streak_q + StreakOne;
                    end
                end else begin
                    streak_d = '0;
                end
            end
            StIresp: begin
                ihit     = 1'b1;
                state_d  = StIdle;
                streak_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed bench for mem_request_responder: a transaction-level model is compared every cycle,
// and each scenario also pins hand-computed hit timing and load values.
module tb_mem_request_responder;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int DMAX = 4;

    localparam int MNone = 0;
    localparam int MData = 1;
    localparam int MInst = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          imemren = 1'b0;
    logic [AW-1:0] imemaddr = '0;
    logic          dmemren = 1'b0;
    logic          dmemwen = 1'b0;
    logic [AW-1:0] dmemaddr = '0;
    logic [DW-1:0] dmemstore = '0;
    logic          ihit;
    logic [DW-1:0] imemload;
    logic          dhit;
    logic [DW-1:0] dmemload;
    logic          ram_ren;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_store;
    logic [DW-1:0] ram_load = '0;
    logic          ram_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_request_responder #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .D_STREAK_MAX (DMAX)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemren   (imemren),
        .imemaddr  (imemaddr),
        .dmemren   (dmemren),
        .dmemwen   (dmemwen),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .ihit      (ihit),
        .imemload  (imemload),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready)
    );

    // Transaction model: which access is in flight, which hit is due, and the streak of data
    // services granted while a fetch waits.
    int            m_srv    = MNone;
    int            m_hit    = MNone;
    int            m_streak = 0;
    logic [DW-1:0] m_dload  = '0;
    logic [DW-1:0] m_iload  = '0;

    always @(posedge CLK) begin
        if (RST) begin
            m_srv    <= MNone;
            m_hit    <= MNone;
            m_streak <= 0;
            m_dload  <= '0;
            m_iload  <= '0;
        end else if (m_hit == MData) begin
            m_hit    <= MNone;
            m_streak <= imemren ? ((m_streak + 1 > DMAX) ? DMAX : m_streak + 1) : 0;
        end else if (m_hit == MInst) begin
            m_hit    <= MNone;
            m_streak <= 0;
        end else if (m_srv == MData) begin
            if (!(dmemren || dmemwen)) begin
                m_srv <= MNone;
            end else if (ram_ready) begin
                m_srv <= MNone;
                m_hit <= MData;
                if (!dmemwen) m_dload <= ram_load;
            end
        end else if (m_srv == MInst) begin
            if (!imemren) begin
                m_srv <= MNone;
            end else if (ram_ready) begin
                m_srv   <= MNone;
                m_hit   <= MInst;
                m_iload <= ram_load;
            end
        end else if ((dmemren || dmemwen) && (!imemren || m_streak < DMAX)) begin
            m_srv <= MData;
        end else if (imemren) begin
            m_srv <= MInst;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic e_ren;
        logic e_wen;
        e_wen = (m_srv == MData) && dmemwen;
        e_ren = (m_srv == MInst) || ((m_srv == MData) && !dmemwen);
        chk("model_ihit", ihit, m_hit == MInst);
        chk("model_dhit", dhit, m_hit == MData);
        chk("model_ram_ren", ram_ren, e_ren);
        chk("model_ram_wen", ram_wen, e_wen);
        if (e_ren || e_wen) chk("model_ram_addr", ram_addr, (m_srv == MData) ? dmemaddr : imemaddr);
        if (e_wen) chk("model_ram_store", ram_store, dmemstore);
        chk("model_dmemload", dmemload, m_dload);
        chk("model_imemload", imemload, m_iload);
    endtask

    // One clock: model comparison on the falling edge, then return just after the rising edge.
    task automatic cyc();
        @(negedge CLK);
        compare_model();
        @(posedge CLK);
        #1;
    endtask

    int order[7];
    int exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};
    int n_hits;
    int d_left;

    initial begin
        // Reset held two edges with a fetch pending and ram_ready high.
        imemren   = 1'b1;
        imemaddr  = 32'h0000_0040;
        ram_ready = 1'b1;
        ram_load  = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        chk("rst_ihit", ihit, 1'b0);
        chk("rst_ram_ren", ram_ren, 1'b0);
        chk("rst_imemload", imemload, '0);
        cyc();
        chk("rst2_ram_ren", ram_ren, 1'b0);
        chk("rst2_dmemload", dmemload, '0);
        RST = 1'b0;
        cyc();
        chk("boot_ihit_early", ihit, 1'b0);
        chk("boot_ram_ren", ram_ren, 1'b1);
        cyc();
        chk("boot_ihit", ihit, 1'b1);
        chk("boot_imemload", imemload, 32'hDEAD_BEEF);
        imemren   = 1'b0;
        ram_ready = 1'b0;
        cyc();
        chk("boot_ihit_once", ihit, 1'b0);

        // Data read with ram_ready arriving in cycle 3.
        dmemren  = 1'b1;
        dmemaddr = 32'h0000_0100;
        cyc();
        chk("rd_ren_c1", ram_ren, 1'b1);
        chk("rd_addr_c1", ram_addr, 32'h0000_0100);
        cyc();
        chk("rd_ren_c2", ram_ren, 1'b1);
        chk("rd_dhit_c2", dhit, 1'b0);
        cyc();
        chk("rd_ren_c3", ram_ren, 1'b1);
        ram_ready = 1'b1;
        ram_load  = 32'h1234_5678;
        cyc();
        chk("rd_dhit_c4", dhit, 1'b1);
        chk("rd_dmemload", dmemload, 32'h1234_5678);
        chk("rd_ren_c4", ram_ren, 1'b0);
        dmemren   = 1'b0;
        ram_ready = 1'b0;
        cyc();
        chk("rd_dhit_c5", dhit, 1'b0);

        // Write with both strobes set: write wins, load register untouched.
        dmemren   = 1'b1;
        dmemwen   = 1'b1;
        dmemaddr  = 32'h0000_0104;
        dmemstore = 32'hA5A5_A5A5;
        ram_ready = 1'b1;
        ram_load  = 32'h7777_7777;
        cyc();
        chk("wr_wen", ram_wen, 1'b1);
        chk("wr_ren", ram_ren, 1'b0);
        chk("wr_store", ram_store, 32'hA5A5_A5A5);
        cyc();
        chk("wr_dhit", dhit, 1'b1);
        chk("wr_dmemload", dmemload, 32'h1234_5678);
        dmemren   = 1'b0;
        dmemwen   = 1'b0;
        cyc();

        // Six back-to-back data reads against a continuously waiting fetch.
        for (int k = 0; k < 7; k++) order[k] = 9;
        n_hits   = 0;
        d_left   = 6;
        imemren  = 1'b1;
        imemaddr = 32'h0000_0400;
        dmemren  = 1'b1;
        dmemaddr = 32'h0000_0200;
        ram_load = 32'hCAFE_F00D;
        for (int t = 0; t < 60 && n_hits < 7; t++) begin
            cyc();
            if (dhit) begin
                order[n_hits] = 1;
                n_hits++;
                d_left--;
                if (d_left == 0) dmemren = 1'b0;
            end else if (ihit) begin
                order[n_hits] = 0;
                n_hits++;
                imemren = 1'b0;
            end
        end
        chk("streak_hit_count", n_hits, 7);
        for (int k = 0; k < 7; k++) chk($sformatf("streak_order%0d", k), order[k], exp_order[k]);
        imemren   = 1'b0;
        dmemren   = 1'b0;
        ram_ready = 1'b0;
        cyc();

        // Abort: dmemren dropped in cycle 2, a late ram_ready must not produce a hit.
        dmemren  = 1'b1;
        dmemaddr = 32'h0000_0300;
        cyc();
        chk("abort_ren_c1", ram_ren, 1'b1);
        cyc();
        dmemren = 1'b0;
        cyc();
        chk("abort_ren_c3", ram_ren, 1'b0);
        chk("abort_dhit_c3", dhit, 1'b0);
        ram_ready = 1'b1;
        ram_load  = 32'hBAD0_BAD0;
        cyc();
        chk("abort_dhit_late", dhit, 1'b0);
        chk("abort_dmemload", dmemload, 32'hCAFE_F00D);
        ram_ready = 1'b0;
        cyc();
        chk("abort_dhit_after", dhit, 1'b0);

        // Reset during DRESP clears the load register; the next access times as from reset.
        dmemren   = 1'b1;
        dmemaddr  = 32'h0000_0500;
        ram_ready = 1'b1;
        ram_load  = 32'h55AA_55AA;
        cyc();
        cyc();
        chk("rstd_dhit", dhit, 1'b1);
        chk("rstd_dmemload_pre", dmemload, 32'h55AA_55AA);
        RST       = 1'b1;
        dmemren   = 1'b0;
        ram_ready = 1'b0;
        cyc();
        chk("rstd_dhit_after", dhit, 1'b0);
        chk("rstd_dmemload", dmemload, '0);
        RST       = 1'b0;
        dmemren   = 1'b1;
        ram_ready = 1'b1;
        ram_load  = 32'h0F0F_0F0F;
        cyc();
        chk("rstd_next_ren", ram_ren, 1'b1);
        chk("rstd_next_dhit_early", dhit, 1'b0);
        cyc();
        chk("rstd_next_dhit", dhit, 1'b1);
        chk("rstd_next_load", dmemload, 32'h0F0F_0F0F);
        dmemren   = 1'b0;
        ram_ready = 1'b0;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
